// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtract controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package serial_sub_pkg;

  // Controller FSM encodings
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bo = borrow out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module fs_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bo
);

  // Difference bit and borrow generation
  always_comb begin
    o_d  = i_a ^ i_b ^ i_bin;
    o_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
  end

endmodule : fs_cell

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: diff = a - b - bin, LSB first through one fs_cell.
// Latency: done pulses WIDTH+1 cycles after an accepted start; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; start while busy/done is ignored.
// Optional: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  logic             w_cell_d;
  logic             w_cell_bo;
  logic [WIDTH-1:0] w_diff_nxt;

  // The single shared subtractor cell always sees the current LSBs and carried borrow
  fs_cell u_fs_cell (
    .i_a   (r_a_sr[0]),
    .i_b   (r_b_sr[0]),
    .i_bin (r_borrow),
    .o_d   (w_cell_d),
    .o_bo  (w_cell_bo)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (r_count == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // New cell difference bit enters at the MSB while the partial result moves right
  always_comb begin
    w_diff_nxt            = r_diff >> 1;
    w_diff_nxt[WIDTH-1]   = w_cell_d;
  end

  // Operand capture, serial stepping and result holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_borrow <= bin;
      r_count  <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_busy) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_borrow <= w_cell_bo;
      r_count  <= r_count + CW'(1);
      r_diff   <= w_diff_nxt;
      if (w_last) begin
        r_bout <= w_cell_bo;
`ifdef SERIAL_SUB_OVF_EN
        // On the last step the shift-register LSBs are the operand sign bits
        r_ovf  <= (r_a_sr[0] ^ r_b_sr[0]) & (r_a_sr[0] ^ w_cell_d);
`endif
      end
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign diff = r_diff;
  assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl at WIDTH=8.
// Latency: checks done at cycle 9 after accept, busy for 8 cycles.
// Backpressure: checks start ignored mid-operation and back-to-back accept.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total;
  int bad;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse; returns at the negedge of the first cycle after accept (n=1)
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    @(negedge clk);
    a     = ta;
    b     = tb_;
    bin   = tbin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_;
    bin   = ~tbin;
  endtask

  // Step negedges from cycle index n0 until done; n_done=0 means the budget expired
  task automatic wait_done(input int n0, output int n_done, output int n_busy);
    int n;
    n      = n0;
    n_done = 0;
    n_busy = 0;
    while (n <= 40) begin
      if (busy) n_busy++;
      if (done) begin
        n_done = n;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, diff, bout} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%h bout=%b exp all 0", busy, done, diff, bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b exp=0", ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int nd, nb;
    launch(8'h35, 8'h12, 1'b0);
    wait_done(1, nd, nb);
    total++;
    if (nd !== 9) begin
      bad++;
      $display("FAIL basic_done_latency got=%0d exp=9", nd);
    end
    total++;
    if (nb !== 8) begin
      bad++;
      $display("FAIL basic_busy_cycles got=%0d exp=8", nb);
    end
    total++;
    if (diff !== 8'h23 || bout !== 1'b0) begin
      bad++;
      $display("FAIL basic_result got diff=%h bout=%b exp diff=23 bout=0", diff, bout);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse got done=%b busy=%b exp 0 0", done, busy);
    end
    total++;
    if (diff !== 8'h23 || bout !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold got diff=%h bout=%b exp diff=23 bout=0", diff, bout);
    end
  endtask

  task automatic test_wrap();
    int nd, nb;
    launch(8'h00, 8'h01, 1'b0);
    wait_done(1, nd, nb);
    total++;
    if (nd !== 9 || diff !== 8'hFF || bout !== 1'b1) begin
      bad++;
      $display("FAIL wrap got at=%0d diff=%h bout=%b exp at=9 diff=ff bout=1", nd, diff, bout);
    end
  endtask

  task automatic test_back_to_back();
    int nd, nb;
    launch(8'h10, 8'h0F, 1'b1);
    wait_done(1, nd, nb);
    total++;
    if (nd !== 9 || diff !== 8'h00 || bout !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first got at=%0d diff=%h bout=%b exp at=9 diff=00 bout=0", nd, diff, bout);
    end
    // Start in the cycle right after done
    launch(8'hFF, 8'hFF, 1'b1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept got busy=%b exp=1", busy);
    end
    wait_done(1, nd, nb);
    total++;
    if (nd !== 9 || diff !== 8'hFF || bout !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got at=%0d diff=%h bout=%b exp at=9 diff=ff bout=1", nd, diff, bout);
    end
  endtask

  task automatic test_start_ignored();
    int nd, nb;
    launch(8'h35, 8'h12, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a     = 8'hAA;
    b     = 8'h00;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, nd, nb);
    total++;
    if (nd !== 9 || diff !== 8'h23 || bout !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start got at=%0d diff=%h bout=%b exp at=9 diff=23 bout=0", nd, diff, bout);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || diff !== 8'h23) begin
      bad++;
      $display("FAIL ignore_no_rerun got busy=%b diff=%h exp busy=0 diff=23", busy, diff);
    end
  endtask

  task automatic test_reset_abort();
    int nd, nb;
    int seen_done;
    launch(8'h35, 8'h12, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, diff, bout} !== 11'd0) begin
      bad++;
      $display("FAIL abort_outputs got busy=%b done=%b diff=%h bout=%b exp all 0", busy, done, diff, bout);
    end
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    total++;
    if (seen_done !== 0) begin
      bad++;
      $display("FAIL abort_no_done got activity=%0d exp=0", seen_done);
    end
    launch(8'h5A, 8'h3C, 1'b1);
    wait_done(1, nd, nb);
    total++;
    if (nd !== 9 || diff !== 8'h1D || bout !== 1'b0) begin
      bad++;
      $display("FAIL abort_recover got at=%0d diff=%h bout=%b exp at=9 diff=1d bout=0", nd, diff, bout);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int nd, nb;
    launch(8'h80, 8'h01, 1'b0);
    wait_done(1, nd, nb);
    total++;
    if (nd !== 9 || diff !== 8'h7F || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set got at=%0d diff=%h ovf=%b exp at=9 diff=7f ovf=1", nd, diff, ovf);
    end
    launch(8'h05, 8'h03, 1'b0);
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear_on_start got=%b exp=0", ovf);
    end
    wait_done(1, nd, nb);
    total++;
    if (nd !== 9 || diff !== 8'h02 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got at=%0d diff=%h ovf=%b exp at=9 diff=02 ovf=0", nd, diff, ovf);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_sub_ctrl
